// File: rtl/slave_reg.sv
// ---------------------------------------------------------------------------
// slave_reg : bus slave register bank
//
// Word-addressed bank of NUM_REGS 32-bit registers behind a wait-state FSM.
// A request is captured in IDLE, held for WAIT_CYCLES wait states, then
// answered in RESP with a one-cycle ready strobe. Writes commit at the end of
// RESP, so a read on the next transfer already sees the new value.
//
// Parameters
//   NUM_REGS    number of registers (power of two, 2..256)
//   BASE_ADDR   byte address of register 0 (4-byte aligned)
//   WAIT_CYCLES wait states between capture and response (0..15)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   valid       request valid, held by the master until ready
//   read/write  request type (both set = decode error, neither = null)
//   addr        byte address
//   write_data  write payload
//   ready       registered one-cycle completion strobe
//   read_data   registered read result, zero whenever ready is low
//   err         (SLAVE_REG_ERR_EN only) miss or read+write, with ready
//
// Optional feature: define SLAVE_REG_ERR_EN to add the err output.
// ---------------------------------------------------------------------------
module slave_reg #(
  parameter int          NUM_REGS    = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] read_data
`ifdef SLAVE_REG_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam logic [16:0] SPAN     = 17'(4 * NUM_REGS);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  req_t                       req_q, req_d;
  logic [NUM_REGS-1:0][31:0]  regs_q, regs_d;
  logic                       ready_q, ready_d;
  logic [31:0]                rdata_q, rdata_d;
`ifdef SLAVE_REG_ERR_EN
  logic                       err_q, err_d;
`endif

  // Decode signals
  logic [16:0]      off;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             go_resp;

  // Request capture: only in IDLE; later bus activity is ignored.
  always_comb begin
    req_d = req_q;
    if (state_q == S_IDLE && valid) begin
      req_d.rd    = read;
      req_d.wr    = write;
      req_d.addr  = addr;
      req_d.wdata = write_data;
    end
  end

  // Decode works on req_d: in the capture cycle that is the live request
  // (needed when WAIT_CYCLES=0), otherwise it equals the held request.
  // A 17-bit subtract makes addresses below BASE_ADDR wrap above SPAN.
  always_comb begin
    off = {1'b0, req_d.addr} - {1'b0, BASE_ADDR};
    hit = (off < SPAN) && (req_d.addr[1:0] == 2'b00);
    idx = off[IDX_W+1:2];
  end

  // FSM next state / outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    ready_d = 1'b0;
    rdata_d = 32'h0;
    go_resp = 1'b0;
`ifdef SLAVE_REG_ERR_EN
    err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (req_q.wr && !req_q.rd && hit) regs_d[idx] = req_q.wdata;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are computed on the edge that
    // enters RESP and are valid for exactly that one cycle.
    if (go_resp) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      if (req_d.rd && !req_d.wr && hit) rdata_d = regs_q[idx];
`ifdef SLAVE_REG_ERR_EN
      // Null transfers are never errors, whatever their address.
      err_d = (req_d.rd && req_d.wr) || ((req_d.rd || req_d.wr) && !hit);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      regs_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
`ifdef SLAVE_REG_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      regs_q  <= regs_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
`ifdef SLAVE_REG_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign read_data = rdata_q;
`ifdef SLAVE_REG_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_slave_reg.sv
// ---------------------------------------------------------------------------
// tb_slave_reg : self-checking bench for slave_reg
//
// Three instances: WAIT_CYCLES = 0, 1 and 3. The WAIT_CYCLES=1 instance is
// checked every cycle against a behavioural model (register array plus a
// queue of expected responses keyed by cycle number). The other two get
// directed latency/data checks with literal expectations.
// ---------------------------------------------------------------------------
module tb_slave_reg;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          NREG = 16;
  localparam int          W1   = 1;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]       valid_s, read_s, write_s, ready_s;
  logic [2:0][15:0] addr_s;
  logic [2:0][31:0] wdata_s, rdata_s;
`ifdef SLAVE_REG_ERR_EN
  logic [2:0]       err_s;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slave_reg #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .valid(valid_s[0]), .read(read_s[0]),
    .write(write_s[0]), .addr(addr_s[0]), .write_data(wdata_s[0]),
    .ready(ready_s[0]), .read_data(rdata_s[0])
`ifdef SLAVE_REG_ERR_EN
    , .err(err_s[0])
`endif
  );

  slave_reg #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) u_w1 (
    .clk(clk), .reset(reset), .valid(valid_s[1]), .read(read_s[1]),
    .write(write_s[1]), .addr(addr_s[1]), .write_data(wdata_s[1]),
    .ready(ready_s[1]), .read_data(rdata_s[1])
`ifdef SLAVE_REG_ERR_EN
    , .err(err_s[1])
`endif
  );

  slave_reg #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .valid(valid_s[2]), .read(read_s[2]),
    .write(write_s[2]), .addr(addr_s[2]), .write_data(wdata_s[2]),
    .ready(ready_s[2]), .read_data(rdata_s[2])
`ifdef SLAVE_REG_ERR_EN
    , .err(err_s[2])
`endif
  );

  // ---------------- model ----------------
  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs[NREG];
  int          rdy_hist[$];
  logic [31:0] rdata_hist[$];
  int          last_rdy_cyc = -1;
  logic [31:0] last_rdata   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mhit(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    return (off >= 0) && (off < 4 * NREG) && (a % 4 == 0);
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
  endtask

  // Compare process for the WAIT_CYCLES=1 instance, every cycle.
  always @(negedge clk) begin
    logic        ev, er;
    logic [31:0] ed;
    ev = 1'b0; er = 1'b0; ed = 32'h0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ev = 1'b1; ed = q[0].data; er = q[0].err;
      void'(q.pop_front());
    end
    chk("ready", {31'h0, ready_s[1]}, {31'h0, ev});
    chk("read_data", rdata_s[1], ed);
`ifdef SLAVE_REG_ERR_EN
    chk("err", {31'h0, err_s[1]}, {31'h0, er});
`endif
    if (ready_s[1] === 1'b1) begin
      last_rdy_cyc = cyc;
      last_rdata   = rdata_s[1];
      rdy_hist.push_back(cyc);
      rdata_hist.push_back(rdata_s[1]);
    end
  end

  // ---------------- drivers ----------------
  // Entry/exit invariant: 1 time unit after a rising edge, in an IDLE cycle.
  task automatic xfer(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [31:0] wd, input bit hold);
    exp_t e;
    bit   h;
    int   idx;
    valid_s[1] = 1'b1; read_s[1] = rd; write_s[1] = wr;
    addr_s[1] = a; wdata_s[1] = wd;
    h   = mhit(a);
    idx = (int'(a) - int'(BASE)) / 4;
    e.cyc  = cyc + W1 + 1;
    e.err  = (rd && wr) || ((rd || wr) && !h);
    e.data = (rd && !wr && h) ? mregs[idx] : 32'h0;
    if (wr && !rd && h) mregs[idx] = wd;
    q.push_back(e);
    repeat (W1 + 2) @(posedge clk);
    #1;
    if (!hold) begin
      valid_s[1] = 1'b0; read_s[1] = 1'b0; write_s[1] = 1'b0;
    end
  endtask

  // Directed transfer on instance k with literal latency / data.
  task automatic dxfer(input int k, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_d);
    int          c0, got;
    logic [31:0] d;
    c0 = cyc; got = -1; d = 32'h0;
    valid_s[k] = 1'b1; read_s[k] = rd; write_s[k] = wr;
    addr_s[k] = a; wdata_s[k] = wd;
    for (int i = 0; i < 12 && got < 0; i++) begin
      @(negedge clk);
      if (ready_s[k] === 1'b1) begin
        got = cyc - c0;
        d   = rdata_s[k];
      end
    end
    @(posedge clk);
    #1;
    valid_s[k] = 1'b0; read_s[k] = 1'b0; write_s[k] = 1'b0;
    chk($sformatf("latency_u%0d", k), got, exp_lat);
    chk($sformatf("data_u%0d", k), d, exp_d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0;
    valid_s = '0; read_s = '0; write_s = '0; addr_s = '0; wdata_s = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, ready_s[1]}, 32'h0);
    chk("reset_rdata", rdata_s[1], 32'h0);

    // Write then read reg 4; first ready two cycles after valid.
    n = cyc;
    xfer(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    chk("first_latency", last_rdy_cyc - n, 32'd2);
    xfer(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
    chk("read_reg4", last_rdata, 32'hDEADBEEF);
    for (int i = 0; i < NREG; i++) xfer(1'b1, 1'b0, 16'(i * 4), 32'h0, 1'b0);

    // Master sequence with valid held high throughout.
    n = rdy_hist.size();
    xfer(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b1);
    xfer(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1);
    xfer(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0);
    chk("b2b_pulses", rdy_hist.size() - n, 32'd3);
    if (rdy_hist.size() - n == 3) begin
      chk("b2b_gap1", rdy_hist[n+1] - rdy_hist[n], 32'd3);
      chk("b2b_gap2", rdy_hist[n+2] - rdy_hist[n+1], 32'd3);
      chk("b2b_rd2", rdata_hist[n+1], 32'hDEADBEEF);
      chk("b2b_rd3", rdata_hist[n+2], 32'h0);
    end

    // Misses: out of range and misaligned.
    xfer(1'b0, 1'b1, 16'h0040, 32'h12345678, 1'b0);
    xfer(1'b0, 1'b1, 16'h0012, 32'h12345678, 1'b0);
    xfer(1'b1, 1'b0, 16'h0040, 32'h0, 1'b0);
    chk("miss_rd_range", last_rdata, 32'h0);
    xfer(1'b1, 1'b0, 16'h0012, 32'h0, 1'b0);
    chk("miss_rd_align", last_rdata, 32'h0);

    // Last register boundary, consecutive read-after-write.
    xfer(1'b0, 1'b1, 16'h003C, 32'h0BADF00D, 1'b1);
    xfer(1'b1, 1'b0, 16'h003C, 32'h0, 1'b0);
    chk("raw_last_reg", last_rdata, 32'h0BADF00D);

    // read=write=1 is a decode error.
    n = cyc;
    xfer(1'b1, 1'b1, 16'h0004, 32'h55AA55AA, 1'b0);
    chk("rw_latency", last_rdy_cyc - n, 32'd2);
    xfer(1'b1, 1'b0, 16'h0004, 32'h0, 1'b0);
    chk("rw_reg1", last_rdata, 32'h0);
    for (int i = 0; i < NREG; i++) xfer(1'b1, 1'b0, 16'(i * 4), 32'h0, 1'b0);

    // Reset in WAIT aborts the write.
    valid_s[1] = 1'b1; read_s[1] = 1'b0; write_s[1] = 1'b1;
    addr_s[1] = 16'h0008; wdata_s[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_s[1] = 1'b0; write_s[1] = 1'b0;
    model_clear();
    n = rdy_hist.size();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_ready", rdy_hist.size() - n, 32'd0);
    xfer(1'b1, 1'b0, 16'h0008, 32'h0, 1'b0);
    chk("abort_rd", last_rdata, 32'h0);
    xfer(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
    chk("reset_cleared", last_rdata, 32'h0);

    // Other wait-state settings.
    dxfer(0, 1'b0, 1'b1, 16'h003C, 32'hA5A5A5A5, 1, 32'h0);
    dxfer(0, 1'b1, 1'b0, 16'h003C, 32'h0,        1, 32'hA5A5A5A5);
    dxfer(2, 1'b0, 1'b1, 16'h003C, 32'hA5A5A5A5, 4, 32'h0);
    dxfer(2, 1'b1, 1'b0, 16'h003C, 32'h0,        4, 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_responses", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_reg.md
Name: slave_reg

Overview:
- Bus slave register bank at the downstream end of the master/slave bus.
- Consumes valid/read/write/addr/write_data transfers from the bus master and returns ready and read_data.
- Implements a small word-addressed register file behind a wait-state FSM, with a fixed, parameterised response latency.
- Also serves as the standard target for master-side sequence tests.

Parameters:
- NUM_REGS, 16: number of 32-bit registers (power of two, 2..256).
- BASE_ADDR, 16'h0000: byte address of register 0 (4-byte aligned).
- WAIT_CYCLES, 1: wait states between request capture and response (0..15).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- valid  input  1  master request valid; held by master until ready
- read  input  1  read request
- write  input  1  write request
- addr  input  16  byte address
- write_data  input  32  write payload
- ready  output  1  transfer-complete strobe, one cycle
- read_data  output  32  read result, valid while ready=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=0, read_data=0, wait counter=0.
  - All NUM_REGS registers cleared to 0.
  - Reset asserted mid-transfer aborts the transfer: no register update, no ready.
- Outputs ready and read_data are registered. ready=1 only in state RESP. read_data=0 whenever ready=0.
- Decode:
  - hit when BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS and addr[1:0]==0.
  - index=(addr-BASE_ADDR)>>2. With defaults, 16'h0010 -> reg 4.
- FSM:
  - IDLE:
    - valid=1: capture addr, write_data, read, write.
    - WAIT_CYCLES>0: load counter=WAIT_CYCLES-1, go WAIT.
    - WAIT_CYCLES=0: go RESP.
    - valid=0: stay.
  - WAIT: decrement counter each cycle; at counter==0 go RESP. Bus inputs ignored.
  - RESP:
    - ready=1 for exactly one cycle.
    - Captured write with hit: register[index] <= captured write_data at the end of this cycle.
    - Captured read with hit: read_data = register[index].
    - Next state always IDLE.
  - Illegal state encoding -> IDLE.
- Latency: valid first high in cycle 0 (IDLE) -> ready high in cycle WAIT_CYCLES+1. Default: cycle 2.
- Back-to-back transfers:
  - The master may hold valid high continuously, changing the request on the edge where it sees ready.
  - The slave samples the new request in the IDLE cycle after RESP.
  - Throughput: one transfer per WAIT_CYCLES+2 cycles.
- Null transfer (valid=1, read=0, write=0): completes normally with ready, no register change, read_data=0.
- read=1 and write=1 together: treated as a decode error, no register change, read_data=0.
- Miss (out of range or misaligned): write ignored, read returns 0, ready still asserted. A transfer is never stalled forever.
- Read-after-write to the same register on consecutive transfers returns the new value, because the write commits at the end of RESP.
- Inputs sampled only in IDLE. Changes to inputs during WAIT/RESP have no effect.

Optional Feature:
- Macro SLAVE_REG_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - err=1 together with ready in RESP when the captured transfer was a miss or had read=write=1.
  - err=0 for null transfers and for hits.
- Undefined: no err port. Errors are silent; all other behaviour is identical.

Test Plan:
- Write 32'hDEADBEEF to 16'h0010, then read 16'h0010 (defaults) -> first ready in cycle 2; read returns 32'hDEADBEEF; reg 4 only changed, all other regs read 0.
- Master sequence (write 0x0010, read 0x0010, null transfer), valid held high continuously -> three ready pulses spaced 3 cycles apart; read_data=32'hDEADBEEF on the second pulse, 0 on the third.
- Write 32'h12345678 to 16'h0040 and to 16'h0012, then read both -> each completes with ready; reads return 0; err=1 on all four transfers when SLAVE_REG_ERR_EN is defined; no register modified.
- Write 16'h0004 with read=write=1 -> ready after 2 cycles, reg 1 unchanged, err=1 with SLAVE_REG_ERR_EN.
- Assert reset=0 during WAIT of a write of 32'hCAFEF00D to 16'h0008 -> ready never pulses; after release, read of 16'h0008 returns 0.
- WAIT_CYCLES=0 and WAIT_CYCLES=3, write then read 16'h003C with 32'hA5A5A5A5 -> ready in cycle 1 and cycle 4 respectively; data read back matches.
